// File: rtl/lsu_ctrl.sv
// Load/store control stage: validates execute-stage requests, drives one req/ack bus
// access with a timeout, and returns extended load data as a one-cycle response pulse.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_dop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dop_q, dop_d;
    logic [1:0]       off_q, off_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             illegal;
    logic             misaligned;
    logic [31:0]      shifted;
    logic [31:0]      ext_data;

    // Request legality; dop[1:0] encodes the access size for every legal dop.
    always_comb begin
        if (req_we) begin
            illegal = (req_dop > 3'd2);
        end else begin
            illegal = (req_dop[1:0] == 2'd3) || (req_dop[2:1] == 2'b11);
        end
        misaligned = ((req_dop[1:0] == 2'd1) && req_addr[0]) ||
                     ((req_dop[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (dop_q)
            3'd0:    ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    ext_data = {24'h0, shifted[7:0]};
            3'd5:    ext_data = {16'h0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dop_d       = dop_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    dop_d = req_dop;
                    off_d = req_addr[1:0];
                    if (illegal || misaligned) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'h0;
                    end else begin
                        state_d    = StBus;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_we_d   = req_we;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (!req_we) begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = 32'h0;
                        end else begin
                            case (req_dop[1:0])
                                2'd0: begin
                                    mem_be_d    = 4'b0001 << req_addr[1:0];
                                    mem_wdata_d = {4{req_wdata[7:0]}};
                                end
                                2'd1: begin
                                    mem_be_d    = 4'b0011 << req_addr[1:0];
                                    mem_wdata_d = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    mem_be_d    = 4'b1111;
                                    mem_wdata_d = req_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            StBus: begin
                // An ack in the final timeout cycle still completes the access.
                if (mem_ack) begin
                    state_d     = StResp;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = mem_we_q ? 32'h0 : ext_data;
                end else if (cnt_q == CntLast) begin
                    state_d     = StResp;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 32'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dop_q       <= 3'd0;
            off_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dop_q       <= dop_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table plus hand-written reset, timeout and
// back-to-back sequences; responses are scoreboarded through an expected-result queue.
module tb_lsu_ctrl;

    localparam int NOACK = 255;
    localparam int NV    = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_dop = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    typedef struct {
        logic        we;
        logic [2:0]  dop;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        logic        pre_err;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    vec_t vecs[NV];
    rsp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    lsu_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_dop   (req_dop),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                check("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic drive_req(input logic we, input logic [2:0] dop, input logic [31:0] addr,
                             input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_dop   = dop;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic run_vec(input vec_t v);
        int   waited;
        int   req_cycles;
        int   exp_cycles;
        bit   done;
        rsp_t r;
        @(negedge clk);
        drive_req(v.we, v.dop, v.addr, v.wdata);
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        r.err  = v.exp_err;
        r.data = v.exp_data;
        exp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.pre_err) begin
            check("err_no_mem_req", {31'h0, mem_req}, 32'd0);
            check("err_rsp_latency", {31'h0, rsp_valid}, 32'd1);
        end else begin
            check("mem_we", {31'h0, mem_we}, {31'h0, v.we});
            check("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
            check("mem_be", {28'h0, mem_be}, {28'h0, v.exp_be});
            check("mem_wdata", mem_wdata, v.exp_wdata);
            req_cycles = 0;
            done = 1'b0;
            while (!done && req_cycles < 40) begin
                if (!mem_req) begin
                    done = 1'b1;
                end else begin
                    req_cycles++;
                    if (req_cycles == v.ack_dly + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.rdata;
                    end
                    @(negedge clk);
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end
            exp_cycles = (v.ack_dly == NOACK) ? 15 : v.ack_dly + 1;
            check("mem_req_cycles", req_cycles, exp_cycles);
            check("bus_rsp_latency", {31'h0, rsp_valid}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int   accept_idx[$];
        int   n_acc;
        rsp_t r;

        //        we    dop    addr          wdata         rdata         dly  pre   err   be       wdata         data
        vecs[0]  = '{1'b1, 3'd1, 32'h0000_0106, 32'hAAAA_BEEF, 32'h0,        2,   1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 3'd0, 32'h0000_0203, 32'h0,        32'h80FF_0012, 0,   1'b0, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 3'd4, 32'h0000_0203, 32'h0,        32'h80FF_0012, 0,   1'b0, 1'b0, 4'b1111, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b0, 3'd5, 32'h0000_0202, 32'h0,        32'h80FF_0012, 1,   1'b0, 1'b0, 4'b1111, 32'h0,        32'h0000_80FF};
        vecs[4]  = '{1'b0, 3'd1, 32'h0000_0202, 32'h0,        32'h80FF_0012, 0,   1'b0, 1'b0, 4'b1111, 32'h0,        32'hFFFF_80FF};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_0200, 32'h0,        32'h1234_5678, 3,   1'b0, 1'b0, 4'b1111, 32'h0,        32'h1234_5678};
        vecs[6]  = '{1'b1, 3'd0, 32'h0000_0101, 32'h0000_00A5, 32'h0,        0,   1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[7]  = '{1'b1, 3'd2, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,        1,   1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[8]  = '{1'b0, 3'd0, 32'h0000_0200, 32'h0,        32'h80FF_0012, 0,   1'b0, 1'b0, 4'b1111, 32'h0,        32'h0000_0012};
        vecs[9]  = '{1'b0, 3'd0, 32'h0000_0201, 32'h0,        32'h0000_7F00, 0,   1'b0, 1'b0, 4'b1111, 32'h0,        32'h0000_007F};
        vecs[10] = '{1'b0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,        0,   1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 3'd1, 32'h0000_0003, 32'h1234_5678, 32'h0,        0,   1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,        0,   1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 3'd4, 32'h0000_0000, 32'h0,        32'h0,        0,   1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[14] = '{1'b0, 3'd6, 32'h0000_0010, 32'h0,        32'h0,        0,   1'b1, 1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[15] = '{1'b0, 3'd2, 32'h0000_0040, 32'h0,        32'h0,        NOACK, 1'b0, 1'b1, 4'b1111, 32'h0,      32'h0};
        vecs[16] = '{1'b0, 3'd2, 32'h0000_0040, 32'h0,        32'hCAFE_F00D, 14,  1'b0, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D};

        // Reset values, including req_ready while reset is asserted.
        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_mem_we", {31'h0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a bus access, then a late ack that must be ignored.
        @(negedge clk);
        drive_req(1'b0, 3'd2, 32'h0000_0080, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst_mem_req_before", {31'h0, mem_req}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_mem_req_async", {31'h0, mem_req}, 32'd0);
        check("midrst_req_ready", {31'h0, req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_mem_req", {31'h0, mem_req}, 32'd0);
        check("late_ack_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("late_ack_req_ready", {31'h0, req_ready}, 32'd1);
        run_vec(vecs[5]);

        // Back-to-back loads with req_valid held and zero-wait acks.
        @(negedge clk);
        drive_req(1'b0, 3'd2, 32'h0000_0400, 32'h0);
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            if (n_acc == 4) req_valid = 1'b0;
            if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h1000_0000 + i;
            end else begin
                mem_ack = 1'b0;
            end
            if (req_ready && req_valid) begin
                accept_idx.push_back(i);
                r.err  = 1'b0;
                r.data = 32'h1000_0000 + i + 1;
                exp_q.push_back(r);
                n_acc++;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("b2b_accept_count", accept_idx.size(), 32'd4);
        for (int i = 1; i < accept_idx.size(); i++) begin
            check("b2b_accept_spacing", accept_idx[i] - accept_idx[i-1], 32'd3);
        end

        repeat (3) @(negedge clk);
        check("rsp_dropped", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
